// File: rtl/mlp_layer_sequencer.sv
// Sequences one fully-connected layer onto a shared neuron MAC: clear, NUM_INPUTS
// multiply-accumulates, a bias step and a result write for each neuron in turn.
module mlp_layer_sequencer #(
  parameter int NUM_INPUTS    = 62,
  parameter int CLOG2_INPUTS  = 6,
  parameter int NUM_NEURONS   = 30,
  parameter int CLOG2_NEURONS = 5,
  parameter int W_ADDR_W      = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_en,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     acc_clr,
  output logic                     mac_en,
  output logic                     use_bias,
  output logic [CLOG2_INPUTS-1:0]  in_addr,
  output logic [W_ADDR_W-1:0]      w_addr,
  output logic                     out_we,
  output logic [CLOG2_NEURONS-1:0] out_addr
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_MAC, S_BIAS, S_WRITE, S_DONE} state_t;

  localparam logic [CLOG2_INPUTS-1:0]  LAST_IN   = CLOG2_INPUTS'(NUM_INPUTS - 1);
  localparam logic [CLOG2_NEURONS-1:0] LAST_NRN  = CLOG2_NEURONS'(NUM_NEURONS - 1);
  localparam logic [W_ADDR_W-1:0]      BASE_STEP = W_ADDR_W'(NUM_INPUTS);

  state_t                     state, state_nxt;
  logic [CLOG2_INPUTS-1:0]    icnt, icnt_nxt;
  logic [CLOG2_NEURONS-1:0]   nrn, nrn_nxt;
  logic [W_ADDR_W-1:0]        base, base_nxt;

  // Everything holds by default, which is also the whole clk_en=0 behaviour.
  always_comb begin
    state_nxt = state;
    icnt_nxt  = icnt;
    nrn_nxt   = nrn;
    base_nxt  = base;
    if (clk_en) begin
      if (abort) begin
        state_nxt = S_IDLE;
        icnt_nxt  = '0;
        nrn_nxt   = '0;
        base_nxt  = '0;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            state_nxt = S_CLEAR;
            nrn_nxt   = '0;
            base_nxt  = '0;
          end
          S_CLEAR: begin
            state_nxt = S_MAC;
            icnt_nxt  = '0;
          end
          S_MAC: begin
            if (icnt == LAST_IN) state_nxt = S_BIAS;
            else                 icnt_nxt  = icnt + 1'b1;
          end
          S_BIAS: state_nxt = S_WRITE;
          S_WRITE: begin
            if (nrn == LAST_NRN) state_nxt = S_DONE;
            else begin
              state_nxt = S_CLEAR;
              nrn_nxt   = nrn + 1'b1;
              base_nxt  = base + BASE_STEP;
            end
          end
          S_DONE: begin
            state_nxt = S_IDLE;
            icnt_nxt  = '0;
            nrn_nxt   = '0;
            base_nxt  = '0;
          end
          default: state_nxt = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      icnt  <= '0;
      nrn   <= '0;
      base  <= '0;
    end else begin
      state <= state_nxt;
      icnt  <= icnt_nxt;
      nrn   <= nrn_nxt;
      base  <= base_nxt;
    end
  end

  // Strobes are gated by clk_en so a stalled cycle never double-counts; busy is not.
  always_comb begin
    busy     = (state != S_IDLE);
    done     = clk_en && (state == S_DONE);
    acc_clr  = clk_en && (state == S_CLEAR);
    mac_en   = clk_en && ((state == S_MAC) || (state == S_BIAS));
    use_bias = clk_en && (state == S_BIAS);
    out_we   = clk_en && (state == S_WRITE);
    out_addr = busy ? nrn : '0;
    in_addr  = '0;
    w_addr   = '0;
    if (state == S_MAC) begin
      in_addr = icnt;
      w_addr  = base + W_ADDR_W'(icnt);
    end else if (state == S_BIAS) begin
      w_addr  = base;
    end
  end

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Directed bench: a 4x3 layer checked cycle by cycle (stall, abort, reset, start while busy)
// and a default-sized 62x30 layer checked for total latency and final addresses.
module tb_mlp_layer_sequencer;

  logic clk = 1'b0, rst = 1'b0, clk_en = 1'b1, abort = 1'b0;
  logic start_s = 1'b0, start_d = 1'b0;
  always #5 clk = ~clk;

  logic       busy_s, done_s, acc_clr_s, mac_en_s, use_bias_s, out_we_s;
  logic [1:0] in_addr_s, out_addr_s;
  logic [3:0] w_addr_s;

  logic        busy_d, done_d, acc_clr_d, mac_en_d, use_bias_d, out_we_d;
  logic [5:0]  in_addr_d;
  logic [10:0] w_addr_d;
  logic [4:0]  out_addr_d;

  mlp_layer_sequencer #(.NUM_INPUTS(4), .CLOG2_INPUTS(2), .NUM_NEURONS(3),
                        .CLOG2_NEURONS(2), .W_ADDR_W(4)) u_small (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start_s), .abort(abort),
    .busy(busy_s), .done(done_s), .acc_clr(acc_clr_s), .mac_en(mac_en_s),
    .use_bias(use_bias_s), .in_addr(in_addr_s), .w_addr(w_addr_s),
    .out_we(out_we_s), .out_addr(out_addr_s));

  mlp_layer_sequencer u_dflt (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start_d), .abort(abort),
    .busy(busy_d), .done(done_d), .acc_clr(acc_clr_d), .mac_en(mac_en_d),
    .use_bias(use_bias_d), .in_addr(in_addr_d), .w_addr(w_addr_d),
    .out_we(out_we_d), .out_addr(out_addr_d));

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic clr, mac, bias, we, dn, bsy;
    logic [1:0] ia;
    logic [3:0] wa;
    logic [1:0] oa;
  } exp_t;

  // Undisturbed 4x3 timeline, start sampled at cycle 0: 7 cycles per neuron from cycle 1.
  function automatic exp_t ref_at(input int c);
    exp_t e = '0;
    int k, p;
    if (c >= 1 && c <= 21) begin
      k = (c - 1) / 7;
      p = (c - 1) % 7;
      e.bsy = 1'b1;
      e.oa  = 2'(k);
      case (p)
        0: e.clr = 1'b1;
        1, 2, 3, 4: begin e.mac = 1'b1; e.ia = 2'(p - 1); e.wa = 4'(4*k + p - 1); end
        5: begin e.mac = 1'b1; e.bias = 1'b1; e.wa = 4'(4*k); end
        default: e.we = 1'b1;
      endcase
    end else if (c == 22) begin
      e.dn = 1'b1; e.bsy = 1'b1; e.oa = 2'd2;
    end
    return e;
  endfunction

  task automatic cmp_small(input string tag, input exp_t e);
    chk({tag, " acc_clr"},  32'(acc_clr_s),  32'(e.clr));
    chk({tag, " mac_en"},   32'(mac_en_s),   32'(e.mac));
    chk({tag, " use_bias"}, 32'(use_bias_s), 32'(e.bias));
    chk({tag, " out_we"},   32'(out_we_s),   32'(e.we));
    chk({tag, " done"},     32'(done_s),     32'(e.dn));
    chk({tag, " busy"},     32'(busy_s),     32'(e.bsy));
    chk({tag, " in_addr"},  32'(in_addr_s),  32'(e.ia));
    chk({tag, " w_addr"},   32'(w_addr_s),   32'(e.wa));
    chk({tag, " out_addr"}, 32'(out_addr_s), 32'(e.oa));
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Full layer with a stray start at cycle 10 that must be ignored.
  task automatic layer_small(input string pfx);
    int ndone = 0;
    for (int c = 0; c <= 24; c++) begin
      start_s = (c == 0 || c == 10);
      #2;
      cmp_small($sformatf("%s c%0d", pfx, c), ref_at(c));
      if (done_s) ndone++;
      step();
    end
    start_s = 1'b0;
    chk({pfx, " done count"}, ndone, 1);
  endtask

  initial begin
    exp_t fz;
    int ndone, nwe, dcyc, lastw, lastoa;

    repeat (2) step();
    chk("reset busy_s", 32'(busy_s), 0);
    cmp_small("reset", '0);
    chk("reset busy_d", 32'(busy_d), 0);
    chk("reset out_addr_d", 32'(out_addr_d), 0);
    rst = 1'b1;
    step();

    layer_small("t1");

    // clk_en low for 3 cycles while neuron 1 sits at in_addr=2.
    fz = ref_at(11);
    fz.mac = 1'b0;
    for (int c = 0; c <= 27; c++) begin
      start_s = (c == 0);
      clk_en  = !(c >= 11 && c <= 13);
      #2;
      if (c < 11)       cmp_small($sformatf("t2 c%0d", c), ref_at(c));
      else if (c <= 13) cmp_small($sformatf("t2 stall c%0d", c), fz);
      else              cmp_small($sformatf("t2 c%0d", c), ref_at(c - 3));
      step();
    end
    clk_en = 1'b1;

    // Abort during neuron 1 bias step, then a clean restart.
    for (int c = 0; c <= 20; c++) begin
      start_s = (c == 0);
      abort   = (c == 13);
      #2;
      if (c <= 13) cmp_small($sformatf("t3 c%0d", c), ref_at(c));
      else         cmp_small($sformatf("t3 post c%0d", c), '0);
      step();
    end
    abort = 1'b0;
    layer_small("t3r");

    // Reset with clk_en low during MAC.
    for (int c = 0; c <= 3; c++) begin
      start_s = (c == 0);
      #2;
      cmp_small($sformatf("t4 c%0d", c), ref_at(c));
      if (c == 3) begin rst = 1'b0; clk_en = 1'b0; end
      step();
    end
    rst = 1'b1; clk_en = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      #2;
      cmp_small($sformatf("t4 post c%0d", c), '0);
      step();
    end

    // Default-sized layer.
    ndone = 0; nwe = 0; dcyc = -1; lastw = -1; lastoa = -1;
    for (int c = 0; c <= 1960; c++) begin
      start_d = (c == 0);
      #2;
      if (done_d) begin ndone++; dcyc = c; end
      if (out_we_d) begin nwe++; lastoa = int'(out_addr_d); end
      if (mac_en_d && !use_bias_d) lastw = int'(w_addr_d);
      step();
    end
    start_d = 1'b0;
    chk("t5 done cycle", dcyc, 1951);
    chk("t5 done count", ndone, 1);
    chk("t5 out_we count", nwe, 30);
    chk("t5 last w_addr", lastw, 1859);
    chk("t5 last out_addr", lastoa, 29);
    chk("t5 idle after", 32'(busy_d), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
